// File: rtl/qdrc_arb_pkg.sv
`default_nettype none
//==============================================================================
// Module      : qdrc_arb_pkg
// Description : Shared types and constants for the two-port QDR controller
//               arbiter. It holds the arbiter FSM state encoding, the
//               requester port identifiers and the read-tag record carried
//               through the read-latency pipeline.
// Revision    : 1.0 - initial release
//==============================================================================
package qdrc_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_WAIT_RDY = 2'd0,
    ST_RUN      = 2'd1,
    ST_DRAIN    = 2'd2
  } arb_state_t;

  // Requester port identifiers (one bit selects the owner).
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // One tag per issued command slot: valid marks an issued read, and owner
  // names the requester that receives the returned word.
  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

endpackage : qdrc_arb_pkg
`default_nettype wire

// File: rtl/qdrc_arb_tag_pipe.sv
`default_nettype none
//==============================================================================
// Module      : qdrc_arb_tag_pipe
// Description : Read-tag shift register, DEPTH entries deep. A tag pushed on
//               one edge reaches the output entry DEPTH-1 edges later. The
//               output lines up with the controller's read-data-valid when
//               DEPTH equals the controller read latency and the push comes
//               from the registered read strobe.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset, empties the pipeline
//   i_push   in   a read was issued this cycle
//   i_owner  in   requester that issued the read
//   o_head   out  tag leaving the pipeline this cycle
//   o_empty  out  no valid tag anywhere in the pipeline
//==============================================================================
module qdrc_arb_tag_pipe
  import qdrc_arb_pkg::*;
#(
  parameter int DEPTH = 10
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    i_push,
  input  logic    i_owner,
  output rd_tag_t o_head,
  output logic    o_empty
);

  rd_tag_t r_tags [DEPTH];

  // Entry DEPTH-1 is loaded and entry 0 is presented. A tag therefore sits in
  // the pipe for DEPTH cycles in total.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tags[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        r_tags[i] <= r_tags[i+1];
      end
      r_tags[DEPTH-1] <= '{valid: i_push, owner: (i_push ? i_owner : PORT0)};
    end
  end

  assign o_head = r_tags[0];

  always_comb begin
    o_empty = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_tags[i].valid) begin
        o_empty = 1'b0;
      end
    end
  end

endmodule : qdrc_arb_tag_pipe
`default_nettype wire

// File: rtl/qdrc_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : qdrc_arbiter
// Description : Two-port arbiter in front of a QDR controller user interface.
//               Grants one requester per cycle, registers the command onto
//               the controller strobes/address/data, and routes returned read
//               words to their issuer through a tag pipeline matched to the
//               controller read latency. Issue is gated on phy_rdy. Outstanding
//               reads drain cleanly when readiness drops.
// Revision    : 1.0 - initial release
//
// Build option:
//   QDRC_ARB_FIXED_PRIO_EN  defined   -> port 0 always wins contention
//                           undefined -> round-robin between the ports
//
// Ports:
//   clk0, reset                 clock / synchronous active-high reset
//   phy_rdy                     controller calibrated and ready
//   reqN_vld/we/addr/wr_data    requester N command (held until reqN_ack)
//   reqN_ack                    combinational grant for requester N
//   reqN_rd_data/rd_dvld        read return to requester N
//   usr_rd_strb/wr_strb/addr/wr_data   registered command to controller
//   usr_rd_data/rd_dvld         read return from controller
//   busy                        not in RUN, or a read is in flight
//   rd_err                      sticky: controller dvld disagreed with tags
//==============================================================================
module qdrc_arbiter
  import qdrc_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 21,
  parameter int RD_LATENCY = 10   // must match the controller, and be >= 2
) (
  input  logic                      clk0,
  input  logic                      reset,
  input  logic                      phy_rdy,
  input  logic                      req0_vld,
  input  logic                      req0_we,
  input  logic [ADDR_WIDTH-1:0]     req0_addr,
  input  logic [2*DATA_WIDTH-1:0]   req0_wr_data,
  output logic                      req0_ack,
  output logic [2*DATA_WIDTH-1:0]   req0_rd_data,
  output logic                      req0_rd_dvld,
  input  logic                      req1_vld,
  input  logic                      req1_we,
  input  logic [ADDR_WIDTH-1:0]     req1_addr,
  input  logic [2*DATA_WIDTH-1:0]   req1_wr_data,
  output logic                      req1_ack,
  output logic [2*DATA_WIDTH-1:0]   req1_rd_data,
  output logic                      req1_rd_dvld,
  output logic                      usr_rd_strb,
  output logic                      usr_wr_strb,
  output logic [ADDR_WIDTH-1:0]     usr_addr,
  output logic [2*DATA_WIDTH-1:0]   usr_wr_data,
  input  logic [2*DATA_WIDTH-1:0]   usr_rd_data,
  input  logic                      usr_rd_dvld,
  output logic                      busy,
  output logic                      rd_err
);

  localparam int c_WORD_W = 2 * DATA_WIDTH;

  arb_state_t              r_state;
  logic                    r_usr_rd_strb;
  logic                    r_usr_wr_strb;
  logic [ADDR_WIDTH-1:0]   r_usr_addr;
  logic [c_WORD_W-1:0]     r_usr_wr_data;
  logic                    r_iss_owner;
  logic                    r_rd_err;

  logic                    w_grant;
  logic                    w_sel;
  logic                    w_we;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [c_WORD_W-1:0]     w_wr_data;
  rd_tag_t                 w_head;
  logic                    w_tag_empty;
  logic                    w_pipe_empty;

  //--------------------------------------------------------------------------
  // Port selection. w_sel is the port that wins if a grant happens.
  //--------------------------------------------------------------------------
`ifdef QDRC_ARB_FIXED_PRIO_EN
  always_comb begin
    w_sel = req0_vld ? PORT0 : PORT1;
  end
`else
  logic r_rr;

  always_comb begin
    if (req0_vld && req1_vld) begin
      w_sel = r_rr;
    end else begin
      w_sel = req0_vld ? PORT0 : PORT1;
    end
  end

  // Pointing at the non-granted port covers both cases: under contention it
  // alternates, and after a lone grant the other port gets the next tie.
  always_ff @(posedge clk0) begin
    if (reset) begin
      r_rr <= PORT0;
    end else if (w_grant) begin
      r_rr <= ~w_sel;
    end
  end
`endif

  // Grants only in RUN with the PHY still ready, so a phy_rdy drop blocks
  // issue in the same cycle, before the FSM has left RUN.
  assign w_grant  = (r_state == ST_RUN) && phy_rdy && !reset && (req0_vld || req1_vld);
  assign req0_ack = w_grant && (w_sel == PORT0);
  assign req1_ack = w_grant && (w_sel == PORT1);

  assign w_we      = (w_sel == PORT1) ? req1_we      : req0_we;
  assign w_addr    = (w_sel == PORT1) ? req1_addr    : req0_addr;
  assign w_wr_data = (w_sel == PORT1) ? req1_wr_data : req0_wr_data;

  //--------------------------------------------------------------------------
  // Read-tag pipeline, loaded from the registered read strobe so the tag
  // output lines up with usr_rd_dvld RD_LATENCY cycles after the strobe.
  //--------------------------------------------------------------------------
  qdrc_arb_tag_pipe #(
    .DEPTH   (RD_LATENCY)
  ) u_tag_pipe (
    .clk     (clk0),
    .rst     (reset),
    .i_push  (r_usr_rd_strb),
    .i_owner (r_iss_owner),
    .o_head  (w_head),
    .o_empty (w_tag_empty)
  );

  // A read on the strobe register has not reached the tag pipe yet, but it
  // is still in flight.
  assign w_pipe_empty = w_tag_empty && !r_usr_rd_strb;

  //--------------------------------------------------------------------------
  // FSM plus registered controller command outputs.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk0) begin
    if (reset) begin
      r_state       <= ST_WAIT_RDY;
      r_usr_rd_strb <= 1'b0;
      r_usr_wr_strb <= 1'b0;
      r_usr_addr    <= '0;
      r_usr_wr_data <= '0;
      r_iss_owner   <= PORT0;
      r_rd_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_WAIT_RDY: if (phy_rdy)      r_state <= ST_RUN;
        ST_RUN:      if (!phy_rdy)     r_state <= ST_DRAIN;
        ST_DRAIN:    if (w_pipe_empty) r_state <= ST_WAIT_RDY;
        default:                       r_state <= ST_WAIT_RDY;
      endcase

      r_usr_rd_strb <= w_grant && !w_we;
      r_usr_wr_strb <= w_grant &&  w_we;
      if (w_grant) begin
        r_usr_addr    <= w_addr;
        r_usr_wr_data <= w_wr_data;
        r_iss_owner   <= w_sel;
      end

      if (usr_rd_dvld != w_head.valid) begin
        r_rd_err <= 1'b1;
      end
    end
  end

  assign usr_rd_strb = r_usr_rd_strb;
  assign usr_wr_strb = r_usr_wr_strb;
  assign usr_addr    = r_usr_addr;
  assign usr_wr_data = r_usr_wr_data;
  assign rd_err      = r_rd_err;

  //--------------------------------------------------------------------------
  // Read return routing.
  //--------------------------------------------------------------------------
  assign req0_rd_data = usr_rd_data;
  assign req1_rd_data = usr_rd_data;
  assign req0_rd_dvld = usr_rd_dvld && w_head.valid && (w_head.owner == PORT0);
  assign req1_rd_dvld = usr_rd_dvld && w_head.valid && (w_head.owner == PORT1);

  assign busy = (r_state != ST_RUN) || !w_pipe_empty;

endmodule : qdrc_arbiter
`default_nettype wire

// File: tb/tb_qdrc_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module      : tb_qdrc_arbiter
// Description : Self-checking bench for qdrc_arbiter. Random requesters feed
//               the arbiter, and a latency-accurate controller model returns
//               read data. A reference model predicts grants, issued commands
//               and read returns into queues that a monitor drains and checks.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_qdrc_arbiter;

  localparam int DW = 36;
  localparam int AW = 21;
  localparam int L  = 10;
  localparam int WW = 2 * DW;

  localparam int M_WAIT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  logic          reset;
  logic          phy_rdy;
  logic          vld  [2];
  logic          we   [2];
  logic [AW-1:0] addr [2];
  logic [WW-1:0] wdat [2];
  logic          ack0, ack1, dv0, dv1;
  logic [WW-1:0] rdat0, rdat1;
  logic          usr_rd_strb, usr_wr_strb, usr_rd_dvld, busy, rd_err;
  logic [AW-1:0] usr_addr;
  logic [WW-1:0] usr_wr_data, usr_rd_data;
  logic          mdl_dvld = 1'b0;
  logic [WW-1:0] mdl_data = '0;
  logic          inj_dvld;

  assign usr_rd_dvld = mdl_dvld | inj_dvld;
  assign usr_rd_data = mdl_data;

  qdrc_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(L)) dut (
    .clk0(clk0), .reset(reset), .phy_rdy(phy_rdy),
    .req0_vld(vld[0]), .req0_we(we[0]), .req0_addr(addr[0]), .req0_wr_data(wdat[0]),
    .req0_ack(ack0), .req0_rd_data(rdat0), .req0_rd_dvld(dv0),
    .req1_vld(vld[1]), .req1_we(we[1]), .req1_addr(addr[1]), .req1_wr_data(wdat[1]),
    .req1_ack(ack1), .req1_rd_data(rdat1), .req1_rd_dvld(dv1),
    .usr_rd_strb(usr_rd_strb), .usr_wr_strb(usr_wr_strb), .usr_addr(usr_addr),
    .usr_wr_data(usr_wr_data), .usr_rd_data(usr_rd_data), .usr_rd_dvld(usr_rd_dvld),
    .busy(busy), .rd_err(rd_err)
  );

  // Read data is a fixed function of the address.
  function automatic logic [WW-1:0] hash(input logic [AW-1:0] a);
    logic [WW-1:0] h;
    for (int i = 0; i < WW; i++) h[i] = a[i % AW] ^ (i % 3 == 0);
    return h;
  endfunction

  // Controller model: a strobe in cycle C returns data in cycle C+L.
  logic [L-2:0]  cp_v = '0;
  logic [AW-1:0] cp_a [L-1];
  always @(posedge clk0) begin
    if (reset) begin
      cp_v     <= '0;
      mdl_dvld <= 1'b0;
      mdl_data <= '0;
    end else begin
      mdl_dvld <= cp_v[L-2];
      mdl_data <= cp_v[L-2] ? hash(cp_a[L-2]) : '0;
      cp_v     <= {cp_v[L-3:0], usr_rd_strb};
      cp_a[0]  <= usr_addr;
      for (int i = 1; i < L - 1; i++) cp_a[i] <= cp_a[i-1];
    end
  end

  // Scoreboard state
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
    logic          owner;
    int            cyc;
  } iss_t;
  typedef struct {
    logic          owner;
    logic [WW-1:0] data;
    int            cyc;
  } ret_t;

  iss_t iq[$];
  ret_t rq[$];
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;
  int   m_mode = M_WAIT;
  logic m_rr = 1'b0;
  logic m_err = 1'b0;
  logic acked [2];

  always @(posedge clk0) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Monitor and reference model, evaluated mid-cycle.
  always @(negedge clk0) begin
    logic g0, g1, sel, due, inflight;
    iss_t it;
    ret_t rt;
    if (reset) begin
      iq.delete();
      rq.delete();
      m_mode = M_WAIT;
      m_rr = 1'b0;
      m_err = 1'b0;
      acked[0] = 1'b0;
      acked[1] = 1'b0;
    end else begin
      // A read is in flight from its strobe cycle up to its return cycle.
      inflight = (rq.size() != 0) ||
                 (iq.size() != 0 && iq[0].cyc == cyc && !iq[0].we);
      chk("busy", busy, (m_mode != M_RUN) || inflight);
      chk("rd_err", rd_err, m_err);

      // Command issue to controller
      if (usr_rd_strb || usr_wr_strb) begin
        if (iq.size() == 0) begin
          chk("unexpected_strobe", {usr_wr_strb, usr_rd_strb}, 0);
        end else begin
          it = iq.pop_front();
          chk("iss_cycle", cyc, it.cyc);
          chk("iss_rd_strb", usr_rd_strb, !it.we);
          chk("iss_wr_strb", usr_wr_strb, it.we);
          chk("iss_addr", usr_addr, it.addr);
          if (it.we) chk("iss_wr_data", usr_wr_data, it.data);
          else rq.push_back('{it.owner, hash(it.addr), cyc + L});
        end
      end else if (iq.size() != 0 && iq[0].cyc <= cyc) begin
        chk("missing_strobe", 0, 1);
        void'(iq.pop_front());
      end

      // Read return routing
      due = (rq.size() != 0 && rq[0].cyc == cyc);
      if (usr_rd_dvld && !due) m_err = 1'b1;
      if (dv0 || dv1) begin
        if (!due) begin
          chk("unexpected_rd_dvld", {dv1, dv0}, 0);
        end else begin
          rt = rq.pop_front();
          chk("rd_owner", {dv1, dv0}, rt.owner ? 2'b10 : 2'b01);
          chk("rd_data0", rdat0, rt.data);
          chk("rd_data1", rdat1, rt.data);
        end
      end else if (due) begin
        chk("missing_rd_dvld", 0, 1);
        void'(rq.pop_front());
      end

      // Expected grant
      g0 = 1'b0;
      g1 = 1'b0;
      if (m_mode == M_RUN && phy_rdy) begin
        if (vld[0] && vld[1]) begin
`ifdef QDRC_ARB_FIXED_PRIO_EN
          g0 = 1'b1;
`else
          if (m_rr) g1 = 1'b1;
          else      g0 = 1'b1;
`endif
        end else begin
          g0 = vld[0];
          g1 = vld[1];
        end
      end
      chk("ack0", ack0, g0);
      chk("ack1", ack1, g1);
      acked[0] = ack0;
      acked[1] = ack1;
      if (g0 || g1) begin
        sel = g1;
        iq.push_back('{we[sel], addr[sel], wdat[sel], sel, cyc + 1});
        m_rr = !sel;
      end

      // Readiness mode for the next cycle
      case (m_mode)
        M_WAIT:  if (phy_rdy)   m_mode = M_RUN;
        M_RUN:   if (!phy_rdy)  m_mode = M_DRAIN;
        default: if (!inflight) m_mode = M_WAIT;
      endcase
    end
  end

  // Stimulus helpers
  task automatic drive(input int pct, input int flip_pct);
    @(posedge clk0); #1;
    if ($urandom_range(0, 99) < flip_pct) phy_rdy = ~phy_rdy;
    for (int n = 0; n < 2; n++) begin
      if (!vld[n] || acked[n]) begin
        vld[n]  = ($urandom_range(0, 99) < pct);
        we[n]   = 1'($urandom_range(0, 1));
        addr[n] = AW'($urandom);
        wdat[n] = WW'({$urandom, $urandom, $urandom});
      end
    end
  endtask

  task automatic do_reset(input int n);
    reset  = 1'b1;
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    repeat (n) @(posedge clk0);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rd_strb"}, usr_rd_strb, 0);
    chk({tag, "_wr_strb"}, usr_wr_strb, 0);
    chk({tag, "_addr"}, usr_addr, 0);
    chk({tag, "_wr_data"}, usr_wr_data, 0);
    chk({tag, "_acks"}, {ack1, ack0}, 0);
    chk({tag, "_dvlds"}, {dv1, dv0}, 0);
    chk({tag, "_rd_err"}, rd_err, 0);
  endtask

  initial begin
    int got;
    reset    = 1'b1;
    phy_rdy  = 1'b0;
    inj_dvld = 1'b0;
    for (int n = 0; n < 2; n++) begin
      vld[n] = 1'b0; we[n] = 1'b0; addr[n] = '0; wdat[n] = '0; acked[n] = 1'b0;
    end
    do_reset(3);
    check_reset("por");

    // Not ready: a held read is not acked until the FSM reaches RUN.
    vld[0] = 1'b1; we[0] = 1'b0; addr[0] = 21'h00010; wdat[0] = '0;
    repeat (5) begin @(posedge clk0); #1; end
    phy_rdy = 1'b1;
    repeat (20) drive(0, 0);

    // Contention from reset: both ports keep requesting.
    do_reset(2);
    phy_rdy = 1'b1;
    repeat (8)  drive(100, 0);
    repeat (15) drive(0, 0);

    // Random traffic with steady readiness, then with readiness toggling.
    repeat (300) drive(60, 0);
    repeat (400) drive(60, 3);
    phy_rdy = 1'b1;
    repeat (25) drive(0, 0);

    // Drain: three reads from port 1, then readiness drops.
    got = 0;
    vld[0] = 1'b0;
    vld[1] = 1'b1; we[1] = 1'b0; addr[1] = AW'(1);
    for (int k = 0; k < 30 && got < 3; k++) begin
      @(posedge clk0); #1;
      if (acked[1]) begin
        got++;
        addr[1] = AW'(got + 1);
      end
    end
    chk("drain_issued", got, 3);
    phy_rdy = 1'b0;
    repeat (25) begin @(posedge clk0); #1; end
    vld[1] = 1'b0;
    phy_rdy = 1'b1;
    repeat (5) begin @(posedge clk0); #1; end

    // Error: controller dvld with nothing outstanding.
    chk("rd_err_before", rd_err, 0);
    inj_dvld = 1'b1;
    @(posedge clk0); #1;
    inj_dvld = 1'b0;
    repeat (6) begin @(posedge clk0); #1; end
    chk("rd_err_sticky", rd_err, 1);

    // Reset five cycles after a read strobe.
    vld[0] = 1'b1; we[0] = 1'b0; addr[0] = 21'h1abcd;
    got = 0;
    for (int k = 0; k < 10 && got == 0; k++) begin
      @(posedge clk0); #1;
      if (acked[0]) got = 1;
    end
    chk("midflight_acked", got, 1);
    vld[0] = 1'b0;
    repeat (5) begin @(posedge clk0); #1; end
    do_reset(1);
    check_reset("midflight");
    repeat (L + 5) begin @(posedge clk0); #1; end
    chk("midflight_rd_err", rd_err, 0);

    chk("iss_queue_empty", iq.size(), 0);
    chk("ret_queue_empty", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule : tb_qdrc_arbiter
`default_nettype wire
